// File: rtl/hc154_pkg.sv
// Shared types and constants for the HC154-style sequenced line decoder.
package hc154_pkg;

   localparam int IDX_W = 4;
   localparam int CNT_W = 4;
   localparam int LINES = 1 << IDX_W;

   localparam logic [LINES-1:0] ALL_HIGH = 16'hFFFF;
   localparam logic [IDX_W-1:0] IDX_LAST = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } hc154_state_e;

endpackage

// File: rtl/hc154_line_decode.sv
// Combinational 4-to-16 active-low line decode; all lines stay high when disabled.
module hc154_line_decode
   import hc154_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [LINES-1:0] lines
);

   always_comb begin
      lines = ALL_HIGH;
      if (en) begin
         lines[idx] = 1'b0;
      end
   end

endmodule

// File: rtl/hc154_seq_decoder.sv
// Sequenced active-low line driver: one timed pulse on a line, or a scan of all
// 16 lines separated by all-high gaps. Every output is registered.
module hc154_seq_decoder
   import hc154_pkg::*;
#(
   parameter int GAP_CYCLES = 2
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             Abort,
   input  logic             Mode,
   input  logic [IDX_W-1:0] Code,
   input  logic [CNT_W-1:0] Width,
   output logic [LINES-1:0] DataOut,
   output logic [IDX_W-1:0] CodeOut,
   output logic             GS,
   output logic             Busy,
   output logic             Done,
   output hc154_state_e     dbg_state
);

   // Start is a request sampled only while Busy is low and Abort is low; the
   // accepting edge latches Code/Width/Mode, and Busy rises with the first pulse.
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

   hc154_state_e     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [IDX_W-1:0] pulse_q, pulse_d;
   logic             finish;

   logic [LINES-1:0] lines_d;
   logic             drive_en;
   logic             gs_d;
   logic             busy_d;
   logic             done_d;

   // State and datapath register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         width_q <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         gap_q   <= '0;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         width_q <= width_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         pulse_q <= pulse_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      width_d = width_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      pulse_d = pulse_q;
      finish  = 1'b0;
      if (Abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  state_d = ST_DRIVE;
                  idx_d   = Code;
                  width_d = Width;
                  mode_d  = Mode;
                  cnt_d   = Width;
                  pulse_d = '0;
               end
            end
            ST_DRIVE: begin
               if (cnt_q == '0) begin
                  // The 16th scan pulse ends straight into IDLE without a gap.
                  if (!mode_q || pulse_q == IDX_LAST) begin
                     state_d = ST_IDLE;
                     finish  = 1'b1;
                  end else begin
                     state_d = ST_GAP;
                     gap_d   = GAP_LOAD;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_q == '0) begin
                  state_d = ST_DRIVE;
                  idx_d   = idx_q + 1'b1;
                  cnt_d   = width_q;
                  pulse_d = pulse_q + 1'b1;
               end else begin
                  gap_d = gap_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output logic: next values of the registered outputs
   assign drive_en = (state_d == ST_DRIVE);

   hc154_line_decode u_line_decode (
      .en    (drive_en),
      .idx   (idx_d),
      .lines (lines_d)
   );

   always_comb begin
      gs_d   = ~drive_en;
      busy_d = (state_d != ST_IDLE);
      done_d = finish;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         DataOut <= ALL_HIGH;
         CodeOut <= '0;
         GS      <= 1'b1;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         DataOut <= lines_d;
         CodeOut <= idx_d;
         GS      <= gs_d;
         Busy    <= busy_d;
         Done    <= done_d;
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_hc154_seq_decoder.sv
// Directed bench for hc154_seq_decoder with a per-cycle line/GS monitor.
module tb_hc154_seq_decoder;
   import hc154_pkg::*;

   logic         Clk;
   logic         Rst;
   logic         Start;
   logic         Abort;
   logic         Mode;
   logic [3:0]   Code;
   logic [3:0]   Width;
   logic [15:0]  DataOut;
   logic [3:0]   CodeOut;
   logic         GS;
   logic         Busy;
   logic         Done;
   hc154_state_e dbg_state;

   int n_vec = 0;
   int n_err = 0;
   logic mon_en = 1'b0;
   logic [15:0] exp_q[$];

   hc154_seq_decoder #(.GAP_CYCLES(2)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .Abort     (Abort),
      .Mode      (Mode),
      .Code      (Code),
      .Width     (Width),
      .DataOut   (DataOut),
      .CodeOut   (CodeOut),
      .GS        (GS),
      .Busy      (Busy),
      .Done      (Done),
      .dbg_state (dbg_state)
   );

   // Clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic req(input logic m, input logic [3:0] c, input logic [3:0] w);
      Start = 1'b1;
      Mode  = m;
      Code  = c;
      Width = w;
   endtask

   // Every cycle: at most one line low, GS is the AND of all lines
   always @(negedge Clk) begin
      if (mon_en) begin
         check("one_low", 32'($countones(~DataOut) <= 1), 32'd1);
         check("gs_and", {31'd0, GS}, {31'd0, &DataOut});
      end
   end

   initial begin
      int run;
      int gap;
      int pulses;
      int cyc;
      logic prev_gs;
      logic seen_done;
      logic [15:0] e;

      Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Mode = 1'b0; Code = 4'h0; Width = 4'h0;

      // Reset values
      tick(); tick();
      check("rst_data", DataOut, 16'hFFFF);
      check("rst_code", CodeOut, 4'h0);
      check("rst_gs", GS, 1'b1);
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_state", dbg_state, ST_IDLE);
      Rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // Single pulse on line 5, width 2 -> 3 cycles
      req(1'b0, 4'd5, 4'd2);
      tick();
      Start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("single_data", DataOut, 16'hFFDF);
         check("single_gs", GS, 1'b0);
         check("single_code", CodeOut, 4'd5);
         check("single_busy", Busy, 1'b1);
         check("single_done_lo", Done, 1'b0);
         tick();
      end
      check("single_end_data", DataOut, 16'hFFFF);
      check("single_end_done", Done, 1'b1);
      check("single_end_busy", Busy, 1'b0);
      tick();
      check("single_done_pulse", Done, 1'b0);

      // Scan from 14, width 0, two gap cycles between pulses
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         e = 16'hFFFF;
         e[(14 + i) % 16] = 1'b0;
         exp_q.push_back(e);
      end
      req(1'b1, 4'd14, 4'd0);
      tick();
      Start = 1'b0; Code = 4'd7; Width = 4'd9; Mode = 1'b0;
      run = 0; gap = 0; pulses = 0; prev_gs = 1'b1; seen_done = 1'b0;
      for (cyc = 0; cyc < 200; cyc++) begin
         if (!GS) begin
            if (prev_gs) begin
               if (pulses > 0) check("scan_gap", gap, 2);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("scan_line", DataOut, e);
               end else begin
                  check("scan_extra_pulse", pulses, 16);
               end
               pulses++;
               run = 0;
            end
            run++;
         end else begin
            if (!prev_gs) begin
               check("scan_width", run, 1);
               gap = 0;
            end
            gap++;
            if (Done) begin
               seen_done = 1'b1;
               break;
            end
         end
         prev_gs = GS;
         tick();
      end
      check("scan_done_seen", seen_done, 1'b1);
      check("scan_pulses", pulses, 16);
      check("scan_queue_empty", exp_q.size(), 0);
      check("scan_last_code", CodeOut, 4'd13);
      tick();

      // Abort in the second DRIVE cycle of line 3, width 7
      req(1'b0, 4'd3, 4'd7);
      tick();
      Start = 1'b0;
      tick();
      check("abort_pre_data", DataOut, 16'hFFF7);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check("abort_data", DataOut, 16'hFFFF);
      check("abort_busy", Busy, 1'b0);
      check("abort_done", Done, 1'b0);
      check("abort_code", CodeOut, 4'd3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_done", Done, 1'b0);
      end

      // Start during Busy is ignored; original pulse completes
      req(1'b0, 4'd3, 4'd3);
      tick();
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("ignore_data", DataOut, 16'hFFF7);
         check("ignore_code", CodeOut, 4'd3);
         if (i == 0) req(1'b1, 4'd9, 4'd0);
         else Start = 1'b0;
         tick();
      end
      check("ignore_done", Done, 1'b1);
      check("ignore_end_data", DataOut, 16'hFFFF);
      tick();
      check("ignore_no_replay", Busy, 1'b0);

      // Start held high: new pulse accepted in the Done cycle
      req(1'b0, 4'd1, 4'd0);
      tick();
      check("b2b_first", DataOut, 16'hFFFD);
      tick();
      check("b2b_done", Done, 1'b1);
      check("b2b_idle_data", DataOut, 16'hFFFF);
      tick();
      check("b2b_second", DataOut, 16'hFFFD);
      check("b2b_busy", Busy, 1'b1);
      Start = 1'b0;
      tick();
      check("b2b_second_done", Done, 1'b1);
      tick();

      // Abort beats Start in IDLE
      req(1'b0, 4'd2, 4'd0);
      Abort = 1'b1;
      tick();
      Start = 1'b0; Abort = 1'b0;
      check("abort_start_busy", Busy, 1'b0);
      check("abort_start_data", DataOut, 16'hFFFF);
      tick();

      // Width 15 gives 16 cycles
      req(1'b0, 4'd15, 4'd15);
      tick();
      Start = 1'b0;
      check("w15_data", DataOut, 16'h7FFF);
      run = 0;
      for (cyc = 0; cyc < 40 && !GS; cyc++) begin
         run++;
         tick();
      end
      check("w15_len", run, 16);
      check("w15_done", Done, 1'b1);
      tick();

      // Reset mid-scan with Start held high
      req(1'b1, 4'd0, 4'd1);
      for (int i = 0; i < 5; i++) tick();
      check("rst_mid_driving", GS, 1'b0);
      check("rst_mid_code", CodeOut, 4'd1);
      Rst = 1'b1;
      tick();
      check("rst_mid_data", DataOut, 16'hFFFF);
      check("rst_mid_code0", CodeOut, 4'h0);
      check("rst_mid_gs", GS, 1'b1);
      check("rst_mid_busy", Busy, 1'b0);
      check("rst_mid_done", Done, 1'b0);
      tick();
      check("rst_hold_busy", Busy, 1'b0);
      Rst = 1'b0;
      tick();
      check("rst_accept_busy", Busy, 1'b1);
      check("rst_accept_data", DataOut, 16'hFFFE);
      Start = 1'b0;
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check("final_idle", Busy, 1'b0);
      tick();

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
